// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: ID-stage forwarding,
// load-use bubble, dmem-wait freeze with timeout error, branch flush, stall counter.

module pipe_hazard_fwd #(
  parameter int RN_W = 5
) (
  input  logic [RN_W-1:0] i_src,
  input  logic            i_ewreg,
  input  logic            i_em2reg,
  input  logic [RN_W-1:0] i_ern,
  input  logic            i_mwreg,
  input  logic            i_mm2reg,
  input  logic [RN_W-1:0] i_mrn,
  output logic [1:0]      o_fwd
);
  logic w_nz;
  assign w_nz = (i_src != '0);

  // A load in EXE has no data yet; the load-use bubble covers that case.
  always_comb begin
    o_fwd = 2'b00;
    if (i_ewreg && !i_em2reg && (i_ern == i_src) && w_nz)
      o_fwd = 2'b01;
    else if (i_mwreg && (i_mrn == i_src) && w_nz)
      o_fwd = i_mm2reg ? 2'b11 : 2'b10;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int RN_W    = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [RN_W-1:0]  rs,
  input  logic [RN_W-1:0]  rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             branch_taken,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [RN_W-1:0]  ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [RN_W-1:0]  mrn,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush,
  output logic             freeze,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NSRC = 2;
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

  state_t                     r_state, w_nxt;
  logic [WC_W-1:0]            r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0]           r_stall_cnt;
  logic                       w_freeze, w_lu, w_stall;
  logic [NSRC-1:0][RN_W-1:0]  w_src;
  logic [NSRC-1:0][1:0]       w_fwd;

  assign w_src = {rt, rs};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_fwd
      pipe_hazard_fwd #(.RN_W(RN_W)) u_fwd (
        .i_src    (w_src[g]),
        .i_ewreg  (ewreg),
        .i_em2reg (em2reg),
        .i_ern    (ern),
        .i_mwreg  (mwreg),
        .i_mm2reg (mm2reg),
        .i_mrn    (mrn),
        .o_fwd    (w_fwd[g])
      );
    end
  endgenerate

  assign w_lu = ewreg && em2reg && (ern != '0) &&
                ((use_rs && (ern == rs)) || (use_rt && (ern == rt)));

  always_comb begin
    w_nxt      = r_state;
    w_wait_nxt = r_wait_cnt;
    w_freeze   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (mem_req && !mem_ack) begin
          w_freeze   = 1'b1;
          w_nxt      = S_MEM_WAIT;
          w_wait_nxt = WC_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          w_nxt      = S_RUN;
          w_wait_nxt = '0;
        end else begin
          w_freeze = 1'b1;
          if (r_wait_cnt == WC_W'(TIMEOUT - 1))
            w_nxt = S_ERROR;
          else
            w_wait_nxt = r_wait_cnt + WC_W'(1);
        end
      end
      S_ERROR: w_freeze = 1'b1;
      default: begin
        w_nxt      = S_RUN;
        w_wait_nxt = '0;
      end
    endcase
  end

  assign w_stall = w_freeze || w_lu;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Outputs are forced to their idle values while clrn is low.
  assign fwda      = clrn ? w_fwd[0] : 2'b00;
  assign fwdb      = clrn ? w_fwd[1] : 2'b00;
  assign freeze    = clrn && w_freeze;
  assign wpcir     = !clrn || !w_stall;
  assign bubble    = clrn && w_lu && !w_freeze;
  assign flush     = clrn && branch_taken && !w_lu && !w_freeze;
  assign err       = (r_state == S_ERROR);
  assign stall_cnt = r_stall_cnt;
endmodule
